// File: rtl/btn_pkg.sv
// btn_pkg: shared definitions for the button event generator.
//   - btn_state_t : FSM state encoding (IDLE=0, PRESSED=1, LONG=2)
//   - BTN_LONG_TICKS / BTN_REPEAT_TICKS : default tick thresholds, used at the
//     top-level instantiation alongside the debouncer's DEBOUNCE_TICKS
//   - btn_max : helper for sizing the shared tick counter
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

    localparam int BTN_LONG_TICKS   = 100;
    localparam int BTN_REPEAT_TICKS = 20;

    function automatic int btn_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_event_gen_if.sv
// btn_event_gen_if: groups the button event generator's inputs and outputs.
//   tick, clean_btn          : timebase strobe and debounced level (into the block)
//   press/release/short/long/repeat_pulse : 1-clk event pulses (out of the block)
//   held                     : level, high while a press is in progress
// Modports: master = the side driving tick/clean_btn and consuming events,
//           slave  = btn_event_gen itself.
interface btn_event_gen_if;
    logic tick;
    logic clean_btn;
    logic press_pulse;
    logic release_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;
    logic held;

    modport master (
        output tick, clean_btn,
        input  press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
    );

    modport slave (
        input  tick, clean_btn,
        output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
    );
endinterface

// File: rtl/btn_edge_det.sv
// btn_edge_det: registers a synchronous level and flags its edges.
// Ports:
//   clk, reset : clock, synchronous active-high reset (clears the history to 0)
//   level      : input level, already in the clk domain
//   rise, fall : combinational edge flags against last cycle's level
// Clearing the history to 0 means a level that is still high after reset is
// seen as a fresh rising edge.
module btn_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise,
    output logic fall
);
    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) level_q <= 1'b0;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;
    assign fall = ~level & level_q;
endmodule

// File: rtl/btn_event_gen.sv
// btn_event_gen: turns a debounced button level into single-cycle events.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset (aborts any press silently)
//   bus   : btn_event_gen_if.slave -- tick/clean_btn in; press, release,
//           short, long, repeat pulses and the held level out
// Parameters: LONG_TICKS (>=2) ticks to long_pulse, REPEAT_TICKS (>=1) repeat period.
// Build option: define BTN_AUTO_REPEAT_EN to enable repeat_pulse while long-held;
// otherwise repeat_pulse is constant 0 and the counter idles in LONG.
// All outputs are registered, so every event appears the cycle after its cause.
module btn_event_gen
    import btn_pkg::*;
#(
    parameter int LONG_TICKS   = BTN_LONG_TICKS,
    parameter int REPEAT_TICKS = BTN_REPEAT_TICKS
) (
    input  logic            clk,
    input  logic            reset,
    btn_event_gen_if.slave  bus
);
    localparam int CW = $clog2(btn_max(LONG_TICKS, REPEAT_TICKS) + 1);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
`endif

    btn_state_t    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          rise, fall;
    logic          press_n, release_n, short_n, long_n, held_n;
    logic          press_q, release_q, short_q, long_q, held_q;
`ifdef BTN_AUTO_REPEAT_EN
    logic          repeat_n, repeat_q;
`endif

    btn_edge_det u_edge (
        .clk   (clk),
        .reset (reset),
        .level (bus.clean_btn),
        .rise  (rise),
        .fall  (fall)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            press_q   <= press_n;
            release_q <= release_n;
            short_q   <= short_n;
            long_q    <= long_n;
            held_q    <= held_n;
`ifdef BTN_AUTO_REPEAT_EN
            repeat_q  <= repeat_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        short_n   = 1'b0;
        long_n    = 1'b0;
`ifdef BTN_AUTO_REPEAT_EN
        repeat_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    press_n = 1'b1;
                end
            end
            PRESSED: begin
                // A fall is checked first so it beats a same-cycle threshold tick.
                if (fall) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                    short_n   = 1'b1;
                end else if (bus.tick) begin
                    if (cnt == LONG_LAST) begin
                        state_n = LONG;
                        cnt_n   = '0;
                        long_n  = 1'b1;
                    end else if (cnt != '1) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            LONG: begin
                if (fall) begin
                    state_n   = IDLE;
                    cnt_n     = '0;
                    release_n = 1'b1;
                end
`ifdef BTN_AUTO_REPEAT_EN
                else if (bus.tick) begin
                    if (cnt == REP_LAST) begin
                        cnt_n    = '0;
                        repeat_n = 1'b1;
                    end else if (cnt != '1) begin
                        cnt_n = cnt + 1'b1;
                    end
                end
`endif
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // held covers the press_pulse cycle through the release_pulse cycle.
        held_n = (state_n != IDLE) | release_n;
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.short_pulse   = short_q;
    assign bus.long_pulse    = long_q;
    assign bus.held          = held_q;
`ifdef BTN_AUTO_REPEAT_EN
    assign bus.repeat_pulse  = repeat_q;
`else
    assign bus.repeat_pulse  = 1'b0;
`endif
endmodule

// File: tb/tb_btn_event_gen.sv
module tb_btn_event_gen;
    localparam int LT = 5;
    localparam int RT = 2;

    logic clk;
    logic reset;
    btn_event_gen_if bus();

    btn_event_gen #(.LONG_TICKS(LT), .REPEAT_TICKS(RT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: tracks only "is the button down" and "ticks since press".
    bit          m_prev;
    int          m_ticks;
    logic [5:0]  m_exp;   // {press, release, short, long, repeat, held}

    int c_press, c_rel, c_short, c_long, c_rep, c_held0;

    function automatic logic [5:0] outs();
        return {bus.press_pulse, bus.release_pulse, bus.short_pulse,
                bus.long_pulse, bus.repeat_pulse, bus.held};
    endfunction

    task automatic model_step(input logic r, input logic b, input logic t);
        logic pr, rl, sh, lg, rp, hd;
        pr = 0; rl = 0; sh = 0; lg = 0; rp = 0; hd = 0;
        if (r) begin
            m_prev  = 0;
            m_ticks = 0;
        end else begin
            if (b && !m_prev) begin
                pr = 1;
                m_ticks = 0;
            end else if (!b && m_prev) begin
                rl = 1;
                sh = (m_ticks < LT);
                m_ticks = 0;
            end else if (b && t) begin
                m_ticks++;
                lg = (m_ticks == LT);
`ifdef BTN_AUTO_REPEAT_EN
                rp = (m_ticks > LT) && ((m_ticks - LT) % RT == 0);
`endif
            end
            hd = b | m_prev;
            m_prev = b;
        end
        m_exp = {pr, rl, sh, lg, rp, hd};
    endtask

    task automatic apply(input logic r, input logic b, input logic t);
        reset = r;
        bus.clean_btn = b;
        bus.tick = t;
        @(posedge clk);
        #1;
        model_step(r, b, t);
    endtask

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (press,rel,short,long,rep,held)", name, act, exp);
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic clr_counts();
        c_press = 0; c_rel = 0; c_short = 0; c_long = 0; c_rep = 0; c_held0 = 0;
    endtask

    // Drive a constant level for nclk cycles, ticking on every period-th cycle
    // (period 0 = no ticks), checking each cycle against the model.
    task automatic seq(input string name, input logic r, input logic b,
                       input int nclk, input int period);
        logic [5:0] o;
        for (int i = 0; i < nclk; i++) begin
            apply(r, b, (period > 0) && (i % period == period - 1));
            o = outs();
            check(name, o, m_exp);
            c_press += int'(o[5]);
            c_rel   += int'(o[4]);
            c_short += int'(o[3]);
            c_long  += int'(o[2]);
            c_rep   += int'(o[1]);
            c_held0 += int'(!o[0]);
        end
    endtask

    typedef struct {
        logic r, b, t;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic b, input logic t, input logic [5:0] e);
        vec_t x;
        x.r = r; x.b = b; x.t = t; x.exp = e;
        return x;
    endfunction

    initial begin
        int exp_rep;
        m_prev = 0; m_ticks = 0; m_exp = '0;
        reset = 1'b1;
        bus.clean_btn = 1'b0;
        bus.tick = 1'b0;

        // Table: short click, long press (tick every clk), then fall on the 5th tick.
        tbl.push_back(v(1, 0, 0, 6'b000000));
        tbl.push_back(v(0, 1, 0, 6'b100001));
        tbl.push_back(v(0, 1, 1, 6'b000001));
        tbl.push_back(v(0, 1, 1, 6'b000001));
        tbl.push_back(v(0, 0, 0, 6'b011001));
        tbl.push_back(v(0, 0, 1, 6'b000000));
        tbl.push_back(v(0, 1, 1, 6'b100001));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, 6'b000001));
        tbl.push_back(v(0, 1, 1, 6'b000101));
        tbl.push_back(v(0, 0, 1, 6'b010001));
        tbl.push_back(v(0, 0, 0, 6'b000000));
        tbl.push_back(v(0, 1, 0, 6'b100001));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, 6'b000001));
        tbl.push_back(v(0, 0, 1, 6'b011001));
        tbl.push_back(v(0, 0, 0, 6'b000000));

        apply(1, 0, 0);
        check("reset", outs(), 6'b000000);
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].r, tbl[i].b, tbl[i].t);
            check($sformatf("tbl[%0d]", i), outs(), tbl[i].exp);
        end

        // Long hold of 11 ticks (tick every 4 clk), then release.
`ifdef BTN_AUTO_REPEAT_EN
        exp_rep = 3;
`else
        exp_rep = 0;
`endif
        seq("idle", 0, 0, 4, 4);
        clr_counts();
        seq("long_hold", 0, 1, 44, 4);
        seq("long_rel", 0, 0, 4, 4);
        check_int("long_count", c_long, 1);
        check_int("long_repeat_count", c_rep, exp_rep);
        check_int("long_short_count", c_short, 0);
        check_int("long_release_count", c_rel, 1);

        // Reset mid-hold at tick 3, button kept high.
        clr_counts();
        seq("rst_hold", 0, 1, 12, 4);
        seq("rst_in", 1, 1, 2, 4);
        seq("rst_after", 0, 1, 4, 4);
        seq("rst_rel", 0, 0, 2, 4);
        check_int("rst_press_count", c_press, 2);
        check_int("rst_release_count", c_rel, 1);

        // Tick-less hold.
        clr_counts();
        seq("noticks", 0, 1, 100, 0);
        check_int("noticks_press", c_press, 1);
        check_int("noticks_long", c_long, 0);
        check_int("noticks_held_low", c_held0, 0);
        seq("noticks_rel", 0, 0, 2, 0);

        // Random stimulus against the model.
        begin
            logic b;
            b = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(9) == 0) b = ~b;
                apply($urandom_range(299) == 0, b, $urandom_range(2) == 0);
                check("random", outs(), m_exp);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/btn_event_gen.md
Name: btn_event_gen

Overview:
- Sits directly downstream of the button debouncer. Consumes its clean, level-stable button signal and the shared timebase tick.
- Turns the button level into single-cycle event pulses: press, release, short-click, long-press and optional auto-repeat.
- Mode/menu FSMs (fan speed, timer set, stopwatch start/stop) consume these pulses instead of raw levels.

Parameters:
- LONG_TICKS, 100: ticks held before long_pulse fires. Legal range ≥ 2.
- REPEAT_TICKS, 20: tick period of repeat_pulse while in long-hold. Legal range ≥ 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick  in  1  one-clk-wide timebase strobe; same strobe that drives the debouncer
- clean_btn  in  1  debounced button level; 1 = pressed
- press_pulse  out  1  1-clk pulse on press
- release_pulse  out  1  1-clk pulse on any release
- short_pulse  out  1  1-clk pulse on release before the long threshold
- long_pulse  out  1  1-clk pulse when the long threshold is reached
- repeat_pulse  out  1  1-clk pulse every REPEAT_TICKS while long-held
- held  out  1  level; 1 while state ≠ IDLE

Behaviour:
- Clock, reset and latency:
  - Single clock domain; clean_btn is already synchronous, so no extra synchronizer.
  - Every output is registered. All outputs are 0 on reset and 0 in the cycle after reset.
- Reset:
  - Sync reset, priority over everything.
  - Clears: state → IDLE, counter → 0, btn_q (registered copy of clean_btn) → 0.
  - Reset mid-press aborts silently: no release or short pulse is generated.
  - If the button is still held when reset deasserts, a fresh press is detected on the next cycle.
- Edge detect:
  - rise = clean_btn & ~btn_q; fall = ~clean_btn & btn_q.
  - btn_q updates every clk.
- FSM states: IDLE, PRESSED, LONG.
- IDLE:
  - On rise → PRESSED, counter ← 0, press_pulse = 1 next cycle.
- PRESSED:
  - On tick, counter increments.
  - On tick with counter == LONG_TICKS-1 → LONG, counter ← 0, long_pulse next cycle.
  - So long_pulse follows the LONG_TICKS-th tick after the press edge.
  - On fall → IDLE, release_pulse and short_pulse together next cycle.
- LONG:
  - On fall → IDLE, release_pulse only (no short_pulse).
  - Repeat counting is defined under Optional Feature.
- Simultaneous events:
  - fall and the threshold tick in the same cycle: fall wins → short_pulse, no long_pulse.
  - tick with no state-relevant condition: ignored outside PRESSED/LONG.
- Pulse separation: at most one of press/long/repeat per cycle. release and short may coincide.
- Widths and counter:
  - Counter width is $clog2(max(LONG_TICKS, REPEAT_TICKS)+1).
  - Counter saturates and never wraps; unreachable with legal parameters.
- held: 1 from the cycle press_pulse asserts through the cycle release_pulse asserts, inclusive.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined:
  - In LONG, counter increments on tick.
  - On tick with counter == REPEAT_TICKS-1: repeat_pulse next cycle, counter ← 0.
  - The first repeat arrives REPEAT_TICKS ticks after long_pulse.
  - fall in the same cycle as a repeat tick: release wins, no repeat_pulse.
- Undefined:
  - repeat_pulse is tied to constant 0.
  - Counter is idle in LONG.
  - No repeat logic is synthesized.

Decomposition:
- Shared package (btn_pkg):
  - state encoding typedef (IDLE=0, PRESSED=1, LONG=2).
  - default tick constants BTN_LONG_TICKS and BTN_REPEAT_TICKS, reused by top-level instantiation alongside the debouncer's DEBOUNCE_TICKS.
- Optional sub-module btn_edge_det: btn_q register plus rise/fall outputs. Small but reusable for other level inputs.
- Everything else stays in one module.

Test Plan (LONG_TICKS=5, REPEAT_TICKS=2, tick every 4 clk):
- Short click: clean_btn high for 3 ticks, then low → press_pulse 1 clk after rise, short_pulse + release_pulse 1 clk after fall; long_pulse never.
- Long hold (repeat off): hold 8 ticks → long_pulse exactly 1 clk after the 5th tick; on release, release_pulse only; repeat_pulse stays 0.
- Auto-repeat (BTN_AUTO_REPEAT_EN defined): hold 11 ticks → long after tick 5, repeat_pulse after ticks 7, 9 and 11; release → release_pulse only.
- Boundary race: fall asserted in the same clk as the 5th tick → short_pulse, no long_pulse, state back to IDLE.
- Reset mid-hold: assert reset at tick 3 while held, for 2 clk → all outputs 0, no release pulse; the button is still high, so press_pulse fires 1 clk after reset deasserts.
- Tick-less hold: clean_btn high for 100 clk with tick=0 → press_pulse only; held = 1 throughout; no long_pulse.
